// File: rtl/ddc_core_mc.sv
// ddc_core_mc: multi-channel digital down-converter core.
//   One input stream (signed I/Q, DW bits each) is mixed against N_CH
//   independent NCOs (PW-bit phase accumulators, 2^TBL_AW-entry sin/cos ROM).
//   Each channel output is rounded (half-up) and saturated to OW bits.
//   Pipeline: S1 phase/address, S2 table read, S3 products, S4 round/saturate.
// Ports:
//   s_axis_aclk             clock (rising edge)
//   rst                     synchronous active-high reset
//   s_axis_tdata/tvalid/tready  input sample {Q, I}
//   cfg_ch/cfg_pinc/cfg_poff/cfg_valid  shadow register write for one channel
//   resync                  load shadows into all channels, clear accumulators
//   m_axis_tdata/tvalid/tready  output, channel k at [k*2*OW +: 2*OW] = {Q, I}

// Per-channel NCO state and mixer datapath.
module ddc_lane #(
  parameter int DW     = 16,
  parameter int PW     = 32,
  parameter int TBL_AW = 10,
  parameter int OW     = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 take_i,    // sample accepted this cycle
  input  logic                 resync_i,
  input  logic                 cfg_we_i,
  input  logic [PW-1:0]        cfg_pinc_i,
  input  logic [PW-1:0]        cfg_poff_i,
  input  logic signed [DW-1:0] s2_i_i,    // sample aligned with S2 table output
  input  logic signed [DW-1:0] s2_q_i,
  output logic [2*OW-1:0]      out_o
);
  localparam int SH    = 2*DW + 1 - OW;
  localparam int SW    = 2*DW + 2;          // one spare bit so the rounding add cannot wrap
  localparam int SH_M1 = (SH > 0) ? SH - 1 : 0;
  localparam logic signed [SW-1:0] RND = (SH > 0) ? (SW'(1) << SH_M1) : '0;
  localparam int NT = 1 << TBL_AW;

  function automatic int trig(input int a, input bit is_sin);
    real amp, ang, r;
    amp = $itor((1 << (DW-1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * $itor(a) / $itor(NT);
    r   = amp * (is_sin ? $sin(ang) : $cos(ang));
    if (r >= 0.0) trig = $rtoi(r + 0.5);
    else          trig = -$rtoi(0.5 - r);
  endfunction

  function automatic logic [OW-1:0] rnd_sat(input logic signed [SW-1:0] v);
    logic signed [SW-1:0] s;
    s = (v + RND) >>> SH;
    if (s[SW-1:OW-1] != {(SW-OW+1){s[SW-1]}})
      rnd_sat = {s[SW-1], {(OW-1){~s[SW-1]}}};
    else
      rnd_sat = s[OW-1:0];
  endfunction

  logic signed [DW-1:0] cos_rom [NT];
  logic signed [DW-1:0] sin_rom [NT];
  for (genvar a = 0; a < NT; a++) begin : g_rom
    localparam logic signed [DW-1:0] CV = DW'(trig(a, 1'b0));
    localparam logic signed [DW-1:0] SV = DW'(trig(a, 1'b1));
    assign cos_rom[a] = CV;
    assign sin_rom[a] = SV;
  end

  logic [PW-1:0] sh_pinc_q, sh_poff_q, pinc_q, poff_q, acc_q;
  logic [PW-1:0] sh_pinc_d, sh_poff_d, acc_d, phase_d;
  logic [TBL_AW-1:0] addr_q;
  logic signed [DW-1:0] cos_q, sin_q;
  logic signed [2*DW-1:0] pic_q, pqs_q, pqc_q, pis_q;
  logic signed [SW-1:0] fi, fq;
  logic [2*OW-1:0] out_q;

  // Shadow write is forwarded so a cfg write alongside resync takes effect at once.
  always_comb begin
    sh_pinc_d = cfg_we_i ? cfg_pinc_i : sh_pinc_q;
    sh_poff_d = cfg_we_i ? cfg_poff_i : sh_poff_q;
    phase_d   = resync_i ? sh_poff_d : acc_q + poff_q;
    acc_d     = acc_q;
    if (resync_i)    acc_d = take_i ? sh_pinc_d : '0;
    else if (take_i) acc_d = acc_q + pinc_q;
  end

  logic unused_phase_lo;
  assign unused_phase_lo = ^phase_d[PW-TBL_AW-1:0];

  assign fi = SW'(pic_q) + SW'(pqs_q);
  assign fq = SW'(pqc_q) - SW'(pis_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_pinc_q <= '0; sh_poff_q <= '0;
      pinc_q    <= '0; poff_q    <= '0; acc_q <= '0;
      addr_q    <= '0; cos_q     <= '0; sin_q <= '0;
      pic_q <= '0; pqs_q <= '0; pqc_q <= '0; pis_q <= '0;
      out_q <= '0;
    end else begin
      sh_pinc_q <= sh_pinc_d;
      sh_poff_q <= sh_poff_d;
      acc_q     <= acc_d;
      if (resync_i) begin
        pinc_q <= sh_pinc_d;
        poff_q <= sh_poff_d;
      end
      if (en_i) begin
        addr_q <= phase_d[PW-1 -: TBL_AW];
        cos_q  <= cos_rom[addr_q];
        sin_q  <= sin_rom[addr_q];
        pic_q  <= s2_i_i * cos_q;
        pqs_q  <= s2_q_i * sin_q;
        pqc_q  <= s2_q_i * cos_q;
        pis_q  <= s2_i_i * sin_q;
        out_q  <= {rnd_sat(fq), rnd_sat(fi)};
      end
    end
  end

  assign out_o = out_q;
endmodule

module ddc_core_mc #(
  parameter int N_CH   = 4,
  parameter int DW     = 16,
  parameter int PW     = 32,
  parameter int TBL_AW = 10,
  parameter int OW     = 32,
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   s_axis_aclk,
  input  logic                   rst,
  input  logic [2*DW-1:0]        s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [CW-1:0]          cfg_ch,
  input  logic [PW-1:0]          cfg_pinc,
  input  logic [PW-1:0]          cfg_poff,
  input  logic                   cfg_valid,
  input  logic                   resync,
  output logic [N_CH*2*OW-1:0]   m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);
  localparam int STAGES = 4;

  logic [STAGES:1] vld_pipe_q;
  logic configured_q;
  logic en, take;
  logic signed [DW-1:0] s1_i_q, s1_q_q, s2_i_q, s2_q_q;
  logic [N_CH-1:0][2*OW-1:0] lane_out;

  assign en            = ~vld_pipe_q[STAGES] | m_axis_tready;
  assign s_axis_tready = en | rst;
  assign take          = s_axis_tvalid & en;
  assign m_axis_tvalid = vld_pipe_q[STAGES];
  assign m_axis_tdata  = lane_out;

  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      vld_pipe_q   <= '0;
      configured_q <= 1'b0;
      s1_i_q <= '0; s1_q_q <= '0; s2_i_q <= '0; s2_q_q <= '0;
    end else begin
      if (resync) configured_q <= 1'b1;
      if (en) begin
        // Samples taken before the first resync are consumed but never marked valid.
        vld_pipe_q <= {vld_pipe_q[STAGES-1:1], s_axis_tvalid & configured_q};
        s1_i_q <= s_axis_tdata[DW-1:0];
        s1_q_q <= s_axis_tdata[2*DW-1:DW];
        s2_i_q <= s1_i_q;
        s2_q_q <= s1_q_q;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    ddc_lane #(.DW(DW), .PW(PW), .TBL_AW(TBL_AW), .OW(OW)) u_lane (
      .clk_i      (s_axis_aclk),
      .rst_i      (rst),
      .en_i       (en),
      .take_i     (take),
      .resync_i   (resync),
      .cfg_we_i   (cfg_valid && (cfg_ch == CW'(k))),
      .cfg_pinc_i (cfg_pinc),
      .cfg_poff_i (cfg_poff),
      .s2_i_i     (s2_i_q),
      .s2_q_i     (s2_q_q),
      .out_o      (lane_out[k])
    );
  end
endmodule

// File: tb/tb_ddc_core_mc.sv
module tb_ddc_core_mc;
  localparam int N_CH = 4, DW = 16, PW = 32, TBL_AW = 10, OW = 32;
  localparam int CW = 2;
  localparam int TW = N_CH*2*OW;
  localparam int SH = 2*DW + 1 - OW;

  logic clk = 1'b0;
  logic rst;
  logic [2*DW-1:0] s_axis_tdata;
  logic s_axis_tvalid, s_axis_tready;
  logic [CW-1:0] cfg_ch;
  logic [PW-1:0] cfg_pinc, cfg_poff;
  logic cfg_valid, resync;
  logic [TW-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tready;

  always #5 clk = ~clk;

  ddc_core_mc #(.N_CH(N_CH), .DW(DW), .PW(PW), .TBL_AW(TBL_AW), .OW(OW)) dut (
    .s_axis_aclk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .cfg_ch(cfg_ch), .cfg_pinc(cfg_pinc), .cfg_poff(cfg_poff), .cfg_valid(cfg_valid),
    .resync(resync),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  int total = 0, bad = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint tbl(input int a, input bit is_sin);
    real amp, ang, r;
    amp = $itor((1 << (DW-1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * $itor(a) / $itor(1 << TBL_AW);
    r   = amp * (is_sin ? $sin(ang) : $cos(ang));
    if (r >= 0.0) tbl = longint'($rtoi(r + 0.5));
    else          tbl = -longint'($rtoi(0.5 - r));
  endfunction

  function automatic logic [OW-1:0] post(input longint v);
    longint hi, lo;
    if (SH > 0) v = (v + (longint'(1) << (SH-1))) >>> SH;
    hi = (longint'(1) << (OW-1)) - 1;
    lo = -hi - 1;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    post = v[OW-1:0];
  endfunction

  typedef logic [PW-1:0] ph_arr_t [N_CH];

  function automatic logic [TW-1:0] model_out(input longint di, input longint dq, input ph_arr_t ph);
    logic [TW-1:0] d;
    longint c, s;
    int a;
    d = '0;
    for (int k = 0; k < N_CH; k++) begin
      a = int'(ph[k] >> (PW - TBL_AW));
      c = tbl(a, 1'b0);
      s = tbl(a, 1'b1);
      d[k*2*OW +: OW]      = post(di*c + dq*s);
      d[k*2*OW + OW +: OW] = post(dq*c - di*s);
    end
    return d;
  endfunction

  function automatic longint fld(input logic [TW-1:0] d, input int k, input bit q);
    fld = longint'($signed(d[k*2*OW + (q ? OW : 0) +: OW]));
  endfunction

  typedef struct { int age; logic [TW-1:0] d; } item_t;
  item_t mq[$];
  logic [PW-1:0] m_shp[N_CH], m_sho[N_CH], m_pinc[N_CH], m_poff[N_CH], m_acc[N_CH];
  bit m_cfgd, m_rst_seen;

  function automatic bit exp_valid();
    return (mq.size() > 0) && (mq[0].age == 4);
  endfunction

  always @(posedge clk) begin
    bit en, ok;
    ph_arr_t ph;
    item_t it;
    if (rst) begin
      mq.delete();
      for (int k = 0; k < N_CH; k++) begin
        m_shp[k] = '0; m_sho[k] = '0; m_pinc[k] = '0; m_poff[k] = '0; m_acc[k] = '0;
      end
      m_cfgd = 0;
      m_rst_seen = 1;
    end else begin
      m_rst_seen = 0;
      en = !exp_valid() || m_axis_tready;
      ok = s_axis_tvalid && en;
      if (en) begin
        foreach (mq[i]) mq[i].age++;
        if (mq.size() > 0 && mq[0].age > 4) void'(mq.pop_front());
      end
      if (cfg_valid && int'(cfg_ch) < N_CH) begin
        m_shp[cfg_ch] = cfg_pinc;
        m_sho[cfg_ch] = cfg_poff;
      end
      for (int k = 0; k < N_CH; k++) begin
        if (resync) begin
          m_pinc[k] = m_shp[k];
          m_poff[k] = m_sho[k];
          ph[k]     = m_poff[k];
          m_acc[k]  = ok ? m_pinc[k] : '0;
        end else begin
          ph[k] = m_acc[k] + m_poff[k];
          if (ok) m_acc[k] = m_acc[k] + m_pinc[k];
        end
      end
      if (ok && m_cfgd) begin
        it.age = 1;
        it.d   = model_out(longint'($signed(s_axis_tdata[DW-1:0])),
                           longint'($signed(s_axis_tdata[2*DW-1:DW])), ph);
        mq.push_back(it);
      end
      if (resync) m_cfgd = 1;
    end
  end

  // Single per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("tvalid", m_axis_tvalid, exp_valid());
      if (exp_valid() && m_axis_tvalid) begin
        total++;
        if (m_axis_tdata !== mq[0].d) begin
          bad++;
          $display("FAIL tdata: got %h expected %h", m_axis_tdata, mq[0].d);
        end
      end
      chk("s_tready", s_axis_tready, (rst || !exp_valid() || m_axis_tready) ? 1 : 0);
      if (m_rst_seen) chk("tdata_after_rst", (m_axis_tdata == '0) ? 1 : 0, 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input int ch, input logic [PW-1:0] p, input logic [PW-1:0] o);
    cfg_valid = 1; cfg_ch = CW'(ch); cfg_pinc = p; cfg_poff = o;
    tick();
    cfg_valid = 0;
  endtask

  task automatic do_resync();
    resync = 1; tick(); resync = 0;
  endtask

  task automatic send_one(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q);
    s_axis_tdata = {q, i}; s_axis_tvalid = 1;
    tick();
    s_axis_tvalid = 0;
  endtask

  task automatic get_out(output logic [TW-1:0] d, output int lat);
    lat = 0; d = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin d = m_axis_tdata; lat = c; break; end
      tick();
    end
    tick();
  endtask

  task automatic count_valid(input int n, output int seen);
    seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (m_axis_tvalid) seen++;
      tick();
    end
  endtask

  initial begin
    logic [TW-1:0] d, held;
    int lat, seen, n_acc, n_col, c;
    bit have_held;
    longint seq2[5], seq1[5], seq0[5];
    longint exp2[5];
    exp2 = '{16383500, 0, -16383500, 0, 16383500};

    rst = 1; s_axis_tdata = '0; s_axis_tvalid = 0; cfg_ch = '0; cfg_pinc = '0; cfg_poff = '0;
    cfg_valid = 0; resync = 0; m_axis_tready = 1;
    tick(); tick();
    @(negedge clk);
    chk("rst_tready", s_axis_tready, 1);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata_zero", (m_axis_tdata == '0) ? 1 : 0, 1);
    chk_on = 1;
    rst = 0;
    tick();

    // Samples before any resync are consumed and dropped.
    send_one(16'sd1000, 16'sd0); send_one(16'sd5, 16'sd7); send_one(-16'sd300, 16'sd9);
    count_valid(8, seen);
    chk("pre_cfg_no_valid", seen, 0);

    cfg(0, 32'h0, 32'h0);
    cfg(1, 32'h0, 32'h4000_0000);
    cfg(2, 32'h4000_0000, 32'h0);
    cfg(3, 32'h1234_5678, 32'h9abc_def0);
    do_resync();

    send_one(16'sd1000, 16'sd0);
    get_out(d, lat);
    chk("latency", lat, 4);
    chk("ch0_I_1000", fld(d, 0, 0), 16383500);
    chk("ch0_Q_1000", fld(d, 0, 1), 0);
    chk("ch1_I_poff90", fld(d, 1, 0), 0);
    chk("ch1_Q_poff90", fld(d, 1, 1), -16383500);
    chk("ch2_I_n0", fld(d, 2, 0), 16383500);

    send_one(16'sd0, 16'sd1000);
    get_out(d, lat);
    chk("ch0_I_q1000", fld(d, 0, 0), 0);
    chk("ch0_Q_q1000", fld(d, 0, 1), 16383500);

    // Stream with a 3-cycle downstream stall; ch2 must walk 0,90,180,270,0 degrees.
    do_resync();
    n_acc = 0; n_col = 0; have_held = 0; held = '0;
    for (c = 0; c < 60 && n_col < 5; c++) begin
      m_axis_tready = !(c >= 6 && c <= 8);
      s_axis_tvalid = (n_acc < 5);
      s_axis_tdata  = {16'sd0, 16'sd1000};
      #1;
      if (s_axis_tvalid && s_axis_tready) n_acc++;
      if (m_axis_tvalid && m_axis_tready) begin
        seq2[n_col] = fld(m_axis_tdata, 2, 0);
        seq1[n_col] = fld(m_axis_tdata, 1, 1);
        seq0[n_col] = fld(m_axis_tdata, 0, 0);
        n_col++;
      end
      if (m_axis_tvalid && !m_axis_tready) begin
        chk("bp_s_tready_low", s_axis_tready, 0);
        if (have_held) chk("bp_tdata_held", (m_axis_tdata == held) ? 1 : 0, 1);
        held = m_axis_tdata; have_held = 1;
      end
      tick();
    end
    s_axis_tvalid = 0; m_axis_tready = 1;
    chk("bp_stall_seen", have_held, 1);
    chk("bp_accepted", n_acc, 5);
    chk("bp_collected", n_col, 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("ch2_seq%0d", i), seq2[i], exp2[i]);
      chk($sformatf("ch1_Q_seq%0d", i), seq1[i], -16383500);
      chk($sformatf("ch0_I_seq%0d", i), seq0[i], 16383500);
    end
    tick(); tick(); tick();

    // Shadow write without resync leaves the active NCO alone.
    cfg(0, 32'h4000_0000, 32'h4000_0000);
    send_one(16'sd1000, 16'sd0);
    get_out(d, lat);
    chk("cfg_no_resync_ch0_I", fld(d, 0, 0), 16383500);

    // Reset mid-stream, with cfg/resync asserted alongside (ignored).
    s_axis_tvalid = 1; s_axis_tdata = {16'sd77, 16'sd1000};
    tick(); tick(); tick(); tick(); tick();
    rst = 1; cfg_valid = 1; cfg_ch = 2'd0; cfg_pinc = 32'h1000_0000; cfg_poff = 32'h0; resync = 1;
    tick();
    rst = 0; cfg_valid = 0; resync = 0; s_axis_tvalid = 0;
    @(negedge clk);
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_tdata_zero", (m_axis_tdata == '0) ? 1 : 0, 1);
    tick();
    send_one(16'sd1000, 16'sd0);
    count_valid(8, seen);
    chk("post_rst_no_valid", seen, 0);

    // Randomized traffic checked by the model every cycle.
    do_resync();
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 399) == 0);
      s_axis_tvalid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 7))
        0:       s_axis_tdata = {16'h8000, 16'h8000};
        1:       s_axis_tdata = {16'h7fff, 16'h8000};
        default: s_axis_tdata = 32'($urandom);
      endcase
      m_axis_tready = ($urandom_range(0, 3) != 0);
      cfg_valid     = ($urandom_range(0, 9) == 0);
      cfg_ch        = CW'($urandom_range(0, N_CH-1));
      cfg_pinc      = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) << 29 : 32'($urandom);
      cfg_poff      = 32'($urandom);
      resync        = ($urandom_range(0, 29) == 0);
      tick();
    end
    rst = 0; cfg_valid = 0; resync = 0; s_axis_tvalid = 0; m_axis_tready = 1;
    tick(); tick(); tick(); tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
